freq_band_detector: RTL and testbench

//  Upstream stage of the scaler system. Consumes the signed audio sample stream from the codec

---
 rtl/freq_band_detector_if.sv | 21 ++
 rtl/freq_band_detector.sv | 146 ++++++++++++++
 tb/tb_freq_band_detector.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/freq_band_detector_if.sv
// Sample stream in, band/window status out, bundled for freq_band_detector.
interface freq_band_detector_if #(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
);
  logic signed [SAMPLE_W-1:0] sample_data;
  logic                       sample_valid;
  logic [2:0]                 freq_flag_freq_flag;
  logic                       window_done;
  logic [CNT_W-1:0]           crossing_count;

  modport master (
    output sample_data, sample_valid,
    input  freq_flag_freq_flag, window_done, crossing_count
  );

  modport slave (
    input  sample_data, sample_valid,
    output freq_flag_freq_flag, window_done, crossing_count
  );
endinterface

// File: rtl/freq_band_detector.sv
// Counts hysteretic rising zero crossings per window of samples, classifies the window
// into a pitch band and publishes it once two consecutive windows agree.
module freq_band_detector #(
  parameter int SAMPLE_W    = 16,
  parameter int WINDOW      = 4800,
  parameter int CNT_W       = 16,
  parameter int HYST        = 256,
  parameter int SILENCE_THR = 512,
  parameter int T1          = 10,
  parameter int T2          = 30,
  parameter int T3          = 80,
  parameter int T4          = 200
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  freq_band_detector_if.slave bus
);
  localparam int IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  localparam logic signed [SAMPLE_W-1:0] HYST_P  = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_N  = SAMPLE_W'(-HYST);
  localparam logic signed [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-2:0]        MAG_MAX = '1;
  localparam logic [SAMPLE_W-2:0]        SIL     = (SAMPLE_W-1)'(SILENCE_THR);
  localparam logic [CNT_W-1:0]           CNT_MAX = '1;
  localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic [4*CNT_W-1:0]         THR = {CNT_W'(T4), CNT_W'(T3), CNT_W'(T2), CNT_W'(T1)};

  typedef enum logic [1:0] {ARM_IDLE, ARM_NEG, ARM_POS} arm_t;

  arm_t              arm_reg, arm_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CNT_W-1:0]  cross_reg, cross_next;
  logic [SAMPLE_W-2:0] peak_reg, peak_next;
  logic [2:0]        cand_reg, cand_next;
  logic [2:0]        prev_cand_reg, prev_cand_next;
  logic [2:0]        flag_reg, flag_next;
  logic              done_reg, done_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic signed [SAMPLE_W-1:0] s;
  logic [SAMPLE_W-1:0]        neg_s;
  logic [SAMPLE_W-2:0]        mag;
  logic                       cross_inc;
  logic [CNT_W-1:0]           cross_acc;
  logic [SAMPLE_W-2:0]        peak_acc;
  logic [3:0]                 ge;
  logic [2:0]                 band;

  assign s     = bus.sample_data;
  assign neg_s = -s;

  always_comb begin
    mag = s[SAMPLE_W-2:0];
    if (s == MOST_NEG) begin
      mag = MAG_MAX;
    end else if (s[SAMPLE_W-1]) begin
      mag = neg_s[SAMPLE_W-2:0];
    end
  end

  assign cross_inc = (arm_reg == ARM_NEG) && (s > HYST_P);
  assign cross_acc = (cross_inc && cross_reg != CNT_MAX) ? cross_reg + 1'b1 : cross_reg;
  assign peak_acc  = (mag > peak_reg) ? mag : peak_reg;

  // Thresholds are strictly increasing, so the band is 1 + thresholds reached.
  for (genvar gi = 0; gi < 4; gi++) begin : g_thr
    assign ge[gi] = (cross_acc >= THR[gi*CNT_W +: CNT_W]);
  end

  assign band = (peak_acc < SIL) ? 3'd0
              : 3'd1 + 3'(ge[0]) + 3'(ge[1]) + 3'(ge[2]) + 3'(ge[3]);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      arm_reg       <= ARM_IDLE;
      idx_reg       <= '0;
      cross_reg     <= '0;
      peak_reg      <= '0;
      cand_reg      <= '0;
      prev_cand_reg <= '0;
      flag_reg      <= '0;
      done_reg      <= 1'b0;
      count_reg     <= '0;
    end else begin
      arm_reg       <= arm_next;
      idx_reg       <= idx_next;
      cross_reg     <= cross_next;
      peak_reg      <= peak_next;
      cand_reg      <= cand_next;
      prev_cand_reg <= prev_cand_next;
      flag_reg      <= flag_next;
      done_reg      <= done_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    arm_next       = arm_reg;
    idx_next       = idx_reg;
    cross_next     = cross_reg;
    peak_next      = peak_reg;
    cand_next      = cand_reg;
    prev_cand_next = prev_cand_reg;
    flag_next      = flag_reg;
    done_next      = 1'b0;
    count_next     = count_reg;

    // Agreement runs the edge after a close and sees the cand registered then.
    if (done_reg) begin
      prev_cand_next = cand_reg;
      if (cand_reg == prev_cand_reg) begin
        flag_next = cand_reg;
      end
    end

    if (bus.sample_valid) begin
      case (arm_reg)
        ARM_IDLE: begin
          if (s > HYST_P)      arm_next = ARM_POS;
          else if (s < HYST_N) arm_next = ARM_NEG;
        end
        ARM_NEG:  if (s > HYST_P) arm_next = ARM_POS;
        ARM_POS:  if (s < HYST_N) arm_next = ARM_NEG;
        default:  arm_next = ARM_IDLE;
      endcase

      if (idx_reg == LAST_IDX) begin
        cand_next  = band;
        count_next = cross_acc;
        done_next  = 1'b1;
        idx_next   = '0;
        cross_next = '0;
        peak_next  = '0;
      end else begin
        idx_next   = idx_reg + 1'b1;
        cross_next = cross_acc;
        peak_next  = peak_acc;
      end
    end
  end

  assign bus.freq_flag_freq_flag = flag_reg;
  assign bus.window_done         = done_reg;
  assign bus.crossing_count      = count_reg;
endmodule

// File: tb/tb_freq_band_detector.sv
// Randomised sine/noise windows against a sample-level reference model; a scoreboard
// monitor checks crossing_count and the agreed band whenever window_done fires.
module tb_freq_band_detector;
  localparam int WINDOW = 4800;
  localparam int HYST   = 256;
  localparam int SIL    = 512;
  localparam real PI    = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst_n;

  freq_band_detector_if #(.SAMPLE_W(16), .CNT_W(16)) bus ();

  freq_band_detector dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  typedef struct {
    int cnt;
    int flag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: last armed polarity (0 none, +1 positive, -1 negative).
  int m_pol, m_idx, m_cross, m_peak, m_prev, m_flag;
  int t_n = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic int classify(input int c, input int pk);
    if (pk < SIL) return 0;
    if (c < 10)   return 1;
    if (c < 30)   return 2;
    if (c < 80)   return 3;
    if (c < 200)  return 4;
    return 5;
  endfunction

  task automatic model_clear();
    m_pol = 0; m_idx = 0; m_cross = 0; m_peak = 0; m_prev = 0; m_flag = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int sv);
    int mag;
    int cand;
    exp_t e;
    mag = (sv < 0) ? -sv : sv;
    if (mag > 32767) mag = 32767;
    if (mag > m_peak) m_peak = mag;
    if (sv > HYST) begin
      if (m_pol == -1 && m_cross < 65535) m_cross++;
      m_pol = 1;
    end else if (sv < -HYST) begin
      m_pol = -1;
    end
    if (m_idx == WINDOW - 1) begin
      cand = classify(m_cross, m_peak);
      if (cand == m_prev) m_flag = cand;
      m_prev = cand;
      e.cnt = m_cross;
      e.flag = m_flag;
      exp_q.push_back(e);
      m_idx = 0; m_cross = 0; m_peak = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic send(input int sv);
    bus.sample_data  = 16'(sv);
    bus.sample_valid = 1'b1;
    model_accept(sv);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b0;
      bus.sample_data  = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'($urandom_range(0, 1));
      bus.sample_data  = 16'($urandom);
      @(posedge clk); #1;
    end
    model_clear();
    rst_n = 1'b1;
  endtask

  // nsamp accepted samples of a sine; optional single gap and random 1-cycle drops.
  task automatic sine_run(input real f, input int amp, input int nsamp,
                          input int gap_at, input int gap_len, input int drop_pct);
    real ph;
    real v;
    ph = real'($urandom_range(0, 359)) * PI / 180.0;
    for (int i = 0; i < nsamp; i++) begin
      if (i == gap_at) idle(gap_len);
      if (drop_pct > 0 && $urandom_range(0, 99) < drop_pct) idle(1);
      v = real'(amp) * $sin(2.0 * PI * f * real'(t_n) / 48000.0 + ph);
      t_n++;
      send(int'(v));
    end
  endtask

  // Scoreboard monitor.
  int   mon_flag = 0;
  int   pend_flag = 0;
  bit   pending = 1'b0;
  exp_t e_mon;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        chk("reset_flag", int'(bus.freq_flag_freq_flag), 0);
        chk("reset_done", int'(bus.window_done), 0);
        chk("reset_count", int'(bus.crossing_count), 0);
        mon_flag = 0;
        pending  = 1'b0;
      end else if (pending) begin
        chk("flag_after_agree", int'(bus.freq_flag_freq_flag), pend_flag);
        chk("done_one_cycle", int'(bus.window_done), 0);
        mon_flag = pend_flag;
        pending  = 1'b0;
      end else if (bus.window_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window_done", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("crossing_count", int'(bus.crossing_count), e_mon.cnt);
          chk("flag_before_agree", int'(bus.freq_flag_freq_flag), mon_flag);
          pend_flag = e_mon.flag;
          pending   = 1'b1;
          $display("window: count=%0d exp_count=%0d next_flag=%0d", bus.crossing_count,
                   e_mon.cnt, e_mon.flag);
        end
      end else begin
        chk("flag_stable", int'(bus.freq_flag_freq_flag), mon_flag);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d windows outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_wait;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    model_clear();
    #1;
    do_reset(3);
    idle(2);

    sine_run(440.0, 8000 + int'($urandom_range(0, 400)), 2 * WINDOW, -1, 0, 0);
    sine_run(3000.0, 8000, WINDOW, -1, 0, 0);
    sine_run(440.0, 8000, WINDOW, -1, 0, 0);
    sine_run(3000.0, 6000 + int'($urandom_range(0, 4000)), 2 * WINDOW, -1, 0, 0);
    sine_run(440.0, 8000, WINDOW, int'($urandom_range(1000, 3000)), 1000, 0);
    idle(3);

    sine_run(440.0, 8000, 2000, -1, 0, 0);
    do_reset(3);
    idle(2);
    sine_run(440.0, 8000, WINDOW, -1, 0, 0);
    sine_run(440.0, 100, WINDOW, -1, 0, 0);

    for (int i = 0; i < WINDOW; i++) send(int'($urandom_range(0, 400)) - 200);

    for (int i = 0; i < WINDOW; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      if (i == 100) send(-32768);
      else send(int'($urandom_range(0, 65535)) - 32768);
    end
    idle(1);

    cnt_wait = 0;
    while ((exp_q.size() != 0 || pending) && cnt_wait < 20) begin
      @(posedge clk); #1;
      cnt_wait++;
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
